// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin built on one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             Borr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_nx;

  assign d     = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nx = (~a_sr[0] & b_sr[0])
               | (~(a_sr[0] ^ b_sr[0]) & br);
  assign busy  = (state != S_IDLE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_SHIFT;
      S_SHIFT: if (cnt == LAST) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      Diff <= '0;
      Borr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bin;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          d_sr <= {d, d_sr[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nx;
          cnt  <= cnt + 1'b1;
        end
        S_DONE: begin
          Diff <= d_sr;
          Borr <= br;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic br_msb;

  // Overflow is the borrow into the MSB differing from the borrow out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_msb <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      if (state == S_SHIFT && cnt == LAST) br_msb <= br;
      if (state == S_DONE) Ovf <= br_msb ^ br;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed operations, scoreboard-checked
// against an integer-arithmetic model of A - B - Bin.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borr;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a),
    .B    (b),
    .Bin  (bin),
    .busy (busy),
    .done (done),
    .Diff (diff),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf  (ovf),
`endif
    .Borr (borr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  function automatic exp_t model(input int av, input int bv, input int bi);
    exp_t e;
    int r, sa, sb, sr;
    r    = av - bv - bi;
    e.d  = W'(r);
    e.bo = (av < bv + bi);
    sa   = (av >= 2 ** (W - 1)) ? av - 2 ** W : av;
    sb   = (bv >= 2 ** (W - 1)) ? bv - 2 ** W : bv;
    sr   = sa - sb - bi;
    e.ov = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
    e.t  = 0;
    return e;
  endfunction

  // Monitor: pops the oldest expectation on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no done");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("diff", int'(diff), int'(e.d));
          chk("borr", int'(borr), int'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", int'(ovf), int'(e.ov));
`endif
          chk("latency", cyc - e.t, W + 1);
          chk("busy_cycles", busy_cnt, W + 1);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1, expected busy=0");
    end
  endtask

  task automatic issue(input int av, input int bv, input int bi);
    exp_t e;
    wait_idle();
    a     = W'(av);
    b     = W'(bv);
    bin   = bi[0];
    start = 1'b1;
    e     = model(av, bv, bi);
    e.t   = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borr", int'(borr), 0);
    rst = 1'b0;

    issue(100, 37, 0);
    issue(8'h00, 8'h01, 0);
    issue(8'h05, 8'h05, 1);
    issue(8'h80, 8'h01, 0);
    issue(8'h7F, 8'hFF, 0);
    issue(8'h05, 8'h03, 0);
    issue(8'hFF, 8'h00, 0);
    issue(8'h00, 8'hFF, 1);

    // A start while busy must be dropped.
    issue(8'h10, 8'h01, 0);
    @(posedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // Reset mid-operation discards the in-flight result.
    issue(8'hAA, 8'h55, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    busy_cnt = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_diff", int'(diff), 0);
    chk("midrst_borr", int'(borr), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(8'hAA, 8'h55, 0);

    for (int i = 0; i < 200; i++)
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)));

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
